// File: rtl/rd_ptr_empty.sv
// Read-domain pointer, Gray pointer, empty/almost-empty, occupancy, underflow.
// Ports: clk, rst_n, rd_en, wq2_wptr_gray in; rd_addr, rd_ptr_gray, empty, almost_empty, rd_count, underflow out.
module rd_ptr_empty #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wq2_wptr_gray,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("rd_ptr_empty: DEPTH must equal 2**ADDR_W");
  end

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wbin;
  logic          empty_q, empty_d;
  logic          ae_q, ae_d;
  logic          uf_q, uf_d;
  logic          rd_fire;

  // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < PW; i++) begin
      wbin[i] = ^(wq2_wptr_gray >> i);
    end
  end

  assign rd_fire = rd_en & ~empty_q;

  always_comb begin
    rbin_d  = rbin_q + {{ADDR_W{1'b0}}, rd_fire};
    gray_d  = rbin_d ^ (rbin_d >> 1);
    // Flags use the post-read pointer and the current sampled write pointer.
    empty_d = (gray_d == wq2_wptr_gray);
    cnt_d   = wbin - rbin_d;
    ae_d    = (cnt_d <= AE_T);
    uf_d    = uf_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q  <= '0;
      gray_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      uf_q    <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      gray_q  <= gray_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      uf_q    <= uf_d;
    end
  end

  assign rd_addr      = rbin_q[ADDR_W-1:0];
  assign rd_ptr_gray  = gray_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_count     = cnt_q;
  assign underflow    = uf_q;

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Scoreboard bench for rd_ptr_empty: driver queues hand-computed results,
// monitor pops and compares at each falling edge or on an explicit sample.
module tb_rd_ptr_empty;

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [3:0] wq2_wptr_gray;
  logic [2:0] rd_addr;
  logic [3:0] rd_ptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_count;
  logic       underflow;

  typedef struct {
    string      name;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       emp;
    logic       ae;
    logic [3:0] cnt;
    logic       uf;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_bad;
  event sample_ev;

  rd_ptr_empty #(.DEPTH(8), .ADDR_W(3), .AE_THRESH(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .wq2_wptr_gray(wq2_wptr_gray),
    .rd_addr      (rd_addr),
    .rd_ptr_gray  (rd_ptr_gray),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drain every queued expectation at the sample point.
  always begin
    @(negedge clk or sample_ev);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (rd_addr !== e.addr || rd_ptr_gray !== e.gray ||
          empty !== e.emp || almost_empty !== e.ae ||
          rd_count !== e.cnt || underflow !== e.uf) begin
        n_bad++;
        $display("FAIL %s: got addr=%0d gray=%b e=%b ae=%b cnt=%0d uf=%b want addr=%0d gray=%b e=%b ae=%b cnt=%0d uf=%b",
                 e.name, rd_addr, rd_ptr_gray, empty, almost_empty,
                 rd_count, underflow, e.addr, e.gray, e.emp, e.ae,
                 e.cnt, e.uf);
      end
    end
  end

  function automatic exp_t mk(string nm, logic [2:0] a, logic [3:0] g,
                              logic em, logic ae, logic [3:0] c,
                              logic u);
    exp_t e;
    e.name = nm; e.addr = a; e.gray = g;
    e.emp = em; e.ae = ae; e.cnt = c; e.uf = u;
    return e;
  endfunction

  // Drive inputs, take one rising edge, queue the expected state.
  task automatic step(input logic re, input logic [3:0] wg,
                      input exp_t e);
    rd_en = re;
    wq2_wptr_gray = wg;
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold_reset(input logic [3:0] wg, input int n,
                            input string nm);
    for (int i = 0; i < n; i++)
      step(1'b0, wg, mk(nm, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0));
  endtask

  logic [2:0] fd_addr [8];
  logic [3:0] fd_gray [8];
  logic [2:0] wr_addr [7];
  logic [3:0] wr_gray [7];

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rd_en = 1'b0;
    wq2_wptr_gray = 4'b0011;

    fd_addr = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    fd_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                4'b0111, 4'b0101, 4'b0100, 4'b1100};
    wr_addr = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    wr_gray = '{4'b1101, 4'b1111, 4'b1110, 4'b1010,
                4'b1011, 4'b1001, 4'b1000};

    @(negedge clk);
    hold_reset(4'b0011, 3, "reset_hold");
    rst_n = 1'b1;
    step(1'b0, 4'b0011,
         mk("reset_release", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd2, 1'b0));

    step(1'b1, 4'b0011,
         mk("drain_rd1", 3'd1, 4'b0001, 1'b0, 1'b1, 4'd1, 1'b0));
    step(1'b1, 4'b0011,
         mk("drain_rd2", 3'd2, 4'b0011, 1'b1, 1'b1, 4'd0, 1'b0));

    for (int i = 0; i < 3; i++)
      step(1'b1, 4'b0011,
           mk("underflow_rd", 3'd2, 4'b0011, 1'b1, 1'b1, 4'd0, 1'b1));
    step(1'b0, 4'b0011,
         mk("underflow_sticky", 3'd2, 4'b0011, 1'b1, 1'b1, 4'd0, 1'b1));

    rst_n = 1'b0;
    hold_reset(4'b1100, 2, "fd_reset");
    rst_n = 1'b1;
    step(1'b0, 4'b1100,
         mk("fd_count8", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd8, 1'b0));
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'b1100,
           mk("fd_read", fd_addr[i], fd_gray[i], (i == 7),
              (i >= 6), 4'(7 - i), 1'b0));

    step(1'b0, 4'b1000,
         mk("wrap_prep", 3'd0, 4'b1100, 1'b0, 1'b0, 4'd7, 1'b0));
    for (int i = 0; i < 7; i++)
      step(1'b1, 4'b1000,
           mk("wrap_walk", wr_addr[i], wr_gray[i], (i == 6),
              (i >= 5), 4'(6 - i), 1'b0));
    step(1'b0, 4'b0001,
         mk("wrap_count2", 3'd7, 4'b1000, 1'b0, 1'b0, 4'd2, 1'b0));
    step(1'b1, 4'b0001,
         mk("wrap_read", 3'd0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b0));

    step(1'b0, 4'b0111,
         mk("ar_count5", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd5, 1'b0));
    step(1'b1, 4'b0111,
         mk("ar_read", 3'd1, 4'b0001, 1'b0, 1'b0, 4'd4, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    q.push_back(mk("ar_immediate", 3'd0, 4'b0000, 1'b1, 1'b1,
                   4'd0, 1'b0));
    ->sample_ev;
    #1;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      step(1'b1, 4'b0111,
           mk("ar_held", 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0));
    rst_n = 1'b1;
    step(1'b0, 4'b0111,
         mk("ar_release", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd5, 1'b0));

    #1;
    if (q.size() != 0) begin
      n_bad += q.size();
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rd_ptr_empty.md
Name: rd_ptr_empty

Overview:
- Read-domain pointer and empty-flag stage of the async FIFO.
- Consumes the write pointer after the two-flop synchroniser has moved it into the read clock domain (4-bit Gray for depth 8).
- Produces the read address for the RAM, the Gray read pointer that goes to the opposite-direction synchroniser, and the empty, almost-empty, occupancy and underflow status.

Parameters:
- DEPTH, 8, FIFO depth in entries; must be a power of two.
- ADDR_W, 3, RAM address width; equals clog2(DEPTH). Pointer width is ADDR_W+1.
- AE_THRESH, 1, almost_empty asserts when rd_count <= AE_THRESH.

Ports:
- clk  input  1  read-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- rd_en  input  1  read request from the consumer.
- wq2_wptr_gray  input  ADDR_W+1  synchronised Gray write pointer, from the synchroniser output.
- rd_addr  output  ADDR_W  RAM read address; equals rbin[ADDR_W-1:0].
- rd_ptr_gray  output  ADDR_W+1  registered Gray read pointer, sent to the write-domain synchroniser.
- empty  output  1  registered; FIFO holds no readable entry.
- almost_empty  output  1  registered.
- rd_count  output  ADDR_W+1  registered occupancy as seen in the read domain, range 0..DEPTH.
- underflow  output  1  sticky; set by a read attempted while empty.

Behaviour:
- Clocking and reset:
  - One clock. rst_n is asynchronous assert, synchronous deassert (handled upstream).
  - While rst_n=0: rbin=0, rd_ptr_gray=0, rd_addr=0, empty=1, almost_empty=1, rd_count=0, underflow=0.
  - Asserting rst_n mid-operation forces these values immediately, with no clock edge needed.
- Read acceptance:
  - rd_fire = rd_en & ~empty, using the registered empty.
  - rbin_next = rbin + rd_fire, modulo 2^(ADDR_W+1); the wrap bit toggles every DEPTH reads.
- Gray pointer:
  - gray_next = rbin_next ^ (rbin_next >> 1).
  - rd_ptr_gray is registered, so it is glitch-free, and changes by exactly one bit per accepted read.
- Empty:
  - empty <= (gray_next == wq2_wptr_gray), registered on the same edge as the pointer update.
  - Full Gray compare: wrap bit included.
- Occupancy:
  - wbin = Gray-to-binary of wq2_wptr_gray, combinational XOR chain from the MSB.
  - rd_count <= wbin - rbin_next, computed in ADDR_W+1 bits and modulo, so it is correct across wrap.
  - almost_empty <= (wbin - rbin_next) <= AE_THRESH.
- Latency:
  - A read accepted at edge N updates rd_addr, rd_ptr_gray, empty and rd_count at edge N.
  - RAM data for rd_addr is the consumer's responsibility.
  - A new write becomes visible here one edge after wq2_wptr_gray changes, i.e. two edges of synchroniser latency plus this register.
- Underflow:
  - rd_en=1 while empty=1 leaves the pointers unchanged and sets underflow on that edge.
  - underflow stays 1 until reset.
- Simultaneous read and write visibility: on an edge where rd_fire=1 and wq2_wptr_gray also advanced, the flags and count use both new values, so they are never stale by more than the sampled input.
- Pessimism: empty and rd_count are conservative because the write pointer is delayed by synchronisation. The block never reports a non-existent entry.
- Input Gray stepping: wq2_wptr_gray may jump several Gray steps between samples when the write clock is faster. The block handles any value whose binary distance from rbin is <= DEPTH.

Test Plan:
- Reset: hold rst_n=0 with clk toggling and wq2_wptr_gray=4'b0011 -> empty=1, almost_empty=1, rd_count=0, rd_addr=0, rd_ptr_gray=0, underflow=0. Release reset, next edge -> empty=0, rd_count=2, almost_empty=0.
- Drain two: from reset, wq2_wptr_gray=4'b0011 (bin 2), then rd_en=1 for 2 cycles:
  - first read -> rd_addr=1, rd_ptr_gray=0001, rd_count=1, almost_empty=1.
  - second read -> rd_addr=2, rd_ptr_gray=0011, empty=1, rd_count=0.
- Underflow: while empty, rd_en=1 for 3 cycles -> rd_addr and rd_ptr_gray hold, underflow=1 from the first edge and stays 1 after rd_en drops.
- Full drain: rbin=0, wq2_wptr_gray=4'b1100 (bin 8) -> rd_count=8. Eight reads -> rd_addr steps 1..7 then 0, rd_ptr_gray=1100, empty=1.
- Wrap arithmetic: rbin=15 (rd_ptr_gray=1000), wq2_wptr_gray=4'b0001 (bin 1) -> rd_count=2. One read -> rd_ptr_gray=0000, rd_addr=0, rd_count=1, empty=0.
- Async reset mid-drain: rd_count=5, rd_en=1, pull rst_n low between edges -> all outputs at reset values immediately, and they remain there until rst_n returns high.
